// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array datapath and its writeback.
//   DATA_WIDTH / ACC_WIDTH : operand and accumulator widths
//   TILE_W / TILE_H        : tile geometry of the array
//   wb_state_e             : writeback FSM states
//   saturate()             : unsigned clamp of a value to out_w bits
package systolic_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH  = 16;
  localparam int TILE_W     = 4;
  localparam int TILE_H     = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } wb_state_e;

  // Values are unsigned; a width of 32 or more passes the value through.
  function automatic logic [31:0] saturate(input logic [31:0] val, input int out_w);
    logic [31:0] max_val;
    if (out_w >= 32) return val;
    max_val = (32'd1 << out_w) - 32'd1;
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/c_tile_writeback_if.sv
// Tile-in / memory-write-out bundle of the C tile writeback block.
//   start, tile_valid, tile_data : control and tile input (driven by master)
//   tile_ready                   : tile can be accepted
//   mem_we, mem_addr, mem_wdata  : single result-memory write port
//   all_done, overflow           : matrix complete pulse, sticky dropped-tile flag
interface c_tile_writeback_if #(
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8,
  parameter int WIDTH     = 4,
  parameter int HEIGHT    = 4,
  parameter int ADDR_W    = 8
);
  logic                              start;
  logic                              tile_valid;
  logic [HEIGHT*WIDTH*ACC_WIDTH-1:0] tile_data;
  logic                              tile_ready;
  logic                              mem_we;
  logic [ADDR_W-1:0]                 mem_addr;
  logic [OUT_WIDTH-1:0]              mem_wdata;
  logic                              all_done;
  logic                              overflow;

  modport slave (
    input  start, tile_valid, tile_data,
    output tile_ready, mem_we, mem_addr, mem_wdata, all_done, overflow
  );

  modport master (
    output start, tile_valid, tile_data,
    input  tile_ready, mem_we, mem_addr, mem_wdata, all_done, overflow
  );
endinterface

// File: rtl/tile_addr_gen.sv
// Position tracking for the tile writeback: element index within the tile,
// tile row/column within the matrix, and the row-major memory address.
//   clr       : zero all counters (has priority over step)
//   step      : advance one element; the last element advances the tile
//   elem_idx  : current element index e (r = e / WIDTH, c = e % WIDTH)
//   mem_addr  : (tile_r*HEIGHT + r)*N_SIZE + tile_c*WIDTH + c
//   in_range  : element lies inside the M_SIZE x N_SIZE matrix
//   last_elem : e is the final element of the tile
//   last_tile : current tile is the final tile of the matrix
module tile_addr_gen #(
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 4,
  parameter int M_SIZE = 12,
  parameter int N_SIZE = 12,
  parameter int ADDR_W = $clog2(M_SIZE*N_SIZE),
  localparam int ELEM_N  = WIDTH*HEIGHT,
  localparam int ELEM_W  = (ELEM_N > 1) ? $clog2(ELEM_N) : 1,
  localparam int TILES_C = (N_SIZE + WIDTH - 1) / WIDTH,
  localparam int TILES_R = (M_SIZE + HEIGHT - 1) / HEIGHT,
  localparam int TC_W    = $clog2(TILES_C + 1),
  localparam int TR_W    = $clog2(TILES_R + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              step,
  output logic [ELEM_W-1:0] elem_idx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              in_range,
  output logic              last_elem,
  output logic              last_tile
);

  logic [ELEM_W-1:0] elem_q, elem_d;
  logic [TC_W-1:0]   tile_c_q, tile_c_d;
  logic [TR_W-1:0]   tile_r_q, tile_r_d;
  logic [31:0]       row, col;

  always_comb begin
    row = 32'(tile_r_q) * 32'(HEIGHT) + 32'(elem_q) / 32'(WIDTH);
    col = 32'(tile_c_q) * 32'(WIDTH)  + 32'(elem_q) % 32'(WIDTH);
  end

  assign elem_idx  = elem_q;
  assign in_range  = (row < 32'(M_SIZE)) && (col < 32'(N_SIZE));
  assign mem_addr  = ADDR_W'(row * 32'(N_SIZE) + col);
  assign last_elem = (elem_q == ELEM_W'(ELEM_N - 1));
  assign last_tile = (tile_r_q == TR_W'(TILES_R - 1)) && (tile_c_q == TC_W'(TILES_C - 1));

  // tile_c runs fastest; the final tile wraps both counters for the next matrix.
  always_comb begin
    elem_d   = elem_q;
    tile_c_d = tile_c_q;
    tile_r_d = tile_r_q;
    if (clr) begin
      elem_d   = '0;
      tile_c_d = '0;
      tile_r_d = '0;
    end else if (step) begin
      if (last_elem) begin
        elem_d = '0;
        if (tile_c_q == TC_W'(TILES_C - 1)) begin
          tile_c_d = '0;
          tile_r_d = (tile_r_q == TR_W'(TILES_R - 1)) ? '0 : tile_r_q + TR_W'(1);
        end else begin
          tile_c_d = tile_c_q + TC_W'(1);
        end
      end else begin
        elem_d = elem_q + ELEM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_q   <= '0;
      tile_c_q <= '0;
      tile_r_q <= '0;
    end else begin
      elem_q   <= elem_d;
      tile_c_q <= tile_c_d;
      tile_r_q <= tile_r_d;
    end
  end

endmodule

// File: rtl/c_tile_writeback.sv
// Serialises finished HEIGHT x WIDTH result tiles into a row-major
// M_SIZE x N_SIZE result memory, one saturated element per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : c_tile_writeback_if slave (tile input, memory write port,
//                all_done pulse, sticky overflow)
//
// state | meaning
// IDLE  | tile_ready high; a tile_valid captures the tile
// DRAIN | one element per cycle to memory; incoming tiles are dropped
module c_tile_writeback
  import systolic_pkg::*;
#(
  parameter int ACC_WIDTH = systolic_pkg::ACC_WIDTH,
  parameter int OUT_WIDTH = systolic_pkg::DATA_WIDTH,
  parameter int WIDTH     = systolic_pkg::TILE_W,
  parameter int HEIGHT    = systolic_pkg::TILE_H,
  parameter int M_SIZE    = 12,
  parameter int N_SIZE    = 12,
  parameter int ADDR_W    = $clog2(M_SIZE*N_SIZE)
) (
  input  logic               clk,
  input  logic               rst_n,
  c_tile_writeback_if.slave  bus
);

  localparam int ELEM_N    = WIDTH*HEIGHT;
  localparam int ELEM_W    = (ELEM_N > 1) ? $clog2(ELEM_N) : 1;
  localparam int TILE_BITS = ELEM_N*ACC_WIDTH;

  wb_state_e              state_q, state_d;
  logic [TILE_BITS-1:0]   tile_q, tile_d;
  logic                   overflow_q, overflow_d;
  logic                   all_done_q, all_done_d;

  logic                   ag_clr, ag_step;
  logic [ELEM_W-1:0]      elem_idx;
  logic [ADDR_W-1:0]      ag_addr;
  logic                   in_range, last_elem, last_tile;
  logic [ACC_WIDTH-1:0]   elem;

  assign elem = tile_q[32'(elem_idx)*ACC_WIDTH +: ACC_WIDTH];

  tile_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .M_SIZE (M_SIZE),
    .N_SIZE (N_SIZE),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (ag_clr),
    .step      (ag_step),
    .elem_idx  (elem_idx),
    .mem_addr  (ag_addr),
    .in_range  (in_range),
    .last_elem (last_elem),
    .last_tile (last_tile)
  );

  always_comb begin
    state_d        = state_q;
    tile_d         = tile_q;
    overflow_d     = overflow_q;
    all_done_d     = 1'b0;
    ag_clr         = 1'b0;
    ag_step        = 1'b0;
    bus.tile_ready = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;

    case (state_q)
      IDLE: begin
        bus.tile_ready = 1'b1;
        if (bus.tile_valid) begin
          tile_d  = bus.tile_data;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Out-of-range cells of an edge tile still burn their cycle.
        ag_step       = 1'b1;
        bus.mem_we    = in_range;
        bus.mem_addr  = ag_addr;
        bus.mem_wdata = OUT_WIDTH'(saturate(32'(elem), OUT_WIDTH));
        if (bus.tile_valid) overflow_d = 1'b1;
        if (last_elem) begin
          state_d    = IDLE;
          all_done_d = last_tile;
        end
      end
      default: state_d = IDLE;
    endcase

    // Restart wins over everything, including a tile arriving the same cycle.
    if (bus.start) begin
      state_d    = IDLE;
      tile_d     = tile_q;
      overflow_d = 1'b0;
      all_done_d = 1'b0;
      ag_clr     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tile_q     <= '0;
      overflow_q <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tile_q     <= tile_d;
      overflow_q <= overflow_d;
      all_done_q <= all_done_d;
    end
  end

  assign bus.all_done = all_done_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_c_tile_writeback.sv
// Self-checking bench for c_tile_writeback: 12x12 instance for the main
// scenarios, 6x6 instance for partial edge tiles. Expected writes come from
// a tile-level reference model in plain arithmetic.
module tb_c_tile_writeback;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  c_tile_writeback_if #(.ACC_WIDTH(16), .OUT_WIDTH(8), .WIDTH(4), .HEIGHT(4), .ADDR_W(8)) bus ();
  c_tile_writeback_if #(.ACC_WIDTH(16), .OUT_WIDTH(8), .WIDTH(4), .HEIGHT(4), .ADDR_W(6)) bus6 ();

  c_tile_writeback #(.ACC_WIDTH(16), .OUT_WIDTH(8), .WIDTH(4), .HEIGHT(4),
                     .M_SIZE(12), .N_SIZE(12), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  c_tile_writeback #(.ACC_WIDTH(16), .OUT_WIDTH(8), .WIDTH(4), .HEIGHT(4),
                     .M_SIZE(6), .N_SIZE(6), .ADDR_W(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(bus6));

  // observed activity
  int w_cyc[$], w_addr[$], w_data[$], d_cyc[$];
  int w6_cyc[$], w6_addr[$], w6_data[$], d6_cyc[$];
  // expected activity
  int e_cyc[$], e_addr[$], e_data[$], ed_cyc[$];
  int m_tr, m_tc;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      w_cyc.push_back(cyc); w_addr.push_back(int'(bus.mem_addr)); w_data.push_back(int'(bus.mem_wdata));
    end
    if (bus.all_done === 1'b1) d_cyc.push_back(cyc);
    if (bus6.mem_we === 1'b1) begin
      w6_cyc.push_back(cyc); w6_addr.push_back(int'(bus6.mem_addr)); w6_data.push_back(int'(bus6.mem_wdata));
    end
    if (bus6.all_done === 1'b1) d6_cyc.push_back(cyc);
  end

  task automatic clear_logs();
    w_cyc.delete(); w_addr.delete(); w_data.delete(); d_cyc.delete();
    w6_cyc.delete(); w6_addr.delete(); w6_data.delete(); d6_cyc.delete();
    e_cyc.delete(); e_addr.delete(); e_data.delete(); ed_cyc.delete();
  endtask

  // Reference: tile accepted at cycle t0 writes element (r,c) at t0+1+r*4+c
  // if it lands inside the matrix; tiles advance column-first.
  task automatic model_tile(input int msz, input int nsz, input int t0, input logic [255:0] d,
                            inout int tr, inout int tc);
    int row, col, v;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        row = tr*4 + r;
        col = tc*4 + c;
        v = int'(d[(r*4+c)*16 +: 16]);
        if (row < msz && col < nsz) begin
          e_cyc.push_back(t0 + 1 + r*4 + c);
          e_addr.push_back(row*nsz + col);
          e_data.push_back(v > 255 ? 255 : v);
        end
      end
    end
    tc++;
    if (tc == (nsz + 3) / 4) begin
      tc = 0;
      tr++;
      if (tr == (msz + 3) / 4) begin
        tr = 0;
        ed_cyc.push_back(t0 + 17);
      end
    end
  endtask

  task automatic send(input logic [255:0] d, output int t);
    int n = 0;
    while (bus.tile_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      checks++; failures++;
      $display("FAIL send_ready_timeout: tile_ready=%b required 1", bus.tile_ready);
    end
    bus.tile_valid = 1'b1; bus.tile_data = d; t = cyc;
    @(negedge clk);
    bus.tile_valid = 1'b0;
  endtask

  task automatic send6(input logic [255:0] d, output int t);
    int n = 0;
    while (bus6.tile_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      checks++; failures++;
      $display("FAIL send6_ready_timeout: tile_ready=%b required 1", bus6.tile_ready);
    end
    bus6.tile_valid = 1'b1; bus6.tile_data = d; t = cyc;
    @(negedge clk);
    bus6.tile_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    m_tr = 0; m_tc = 0;
  endtask

  function automatic logic [255:0] rand_tile(input int maxv);
    logic [255:0] d;
    for (int i = 0; i < 16; i++) d[i*16 +: 16] = 16'($urandom_range(0, maxv));
    return d;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.tile_ready !== 1'b1) begin failures++; $display("FAIL reset_tile_ready: got %b required 1", bus.tile_ready); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b required 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 8'd0) begin failures++; $display("FAIL reset_mem_addr: got %0d required 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 8'd0) begin failures++; $display("FAIL reset_mem_wdata: got %0d required 0", bus.mem_wdata); end
    checks++; if (bus.all_done !== 1'b0) begin failures++; $display("FAIL reset_all_done: got %b required 0", bus.all_done); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b required 0", bus.overflow); end
    rst_n = 1'b1;
    @(negedge clk);
    m_tr = 0; m_tc = 0;
  endtask

  task automatic test_single();
    logic [255:0] d;
    int t;
    clear_logs();
    for (int i = 0; i < 16; i++) d[i*16 +: 16] = 16'(i);
    send(d, t);
    model_tile(12, 12, t, d, m_tr, m_tc);
    repeat (20) @(negedge clk);
    checks++;
    if (w_cyc.size() != e_cyc.size()) begin
      failures++; $display("FAIL single_count: got %0d writes required %0d", w_cyc.size(), e_cyc.size());
    end else begin
      for (int i = 0; i < e_cyc.size(); i++) begin
        checks++;
        if (w_cyc[i] != e_cyc[i] || w_addr[i] != e_addr[i] || w_data[i] != e_data[i]) begin
          failures++;
          $display("FAIL single_write[%0d]: got cyc=%0d addr=%0d data=%0d required cyc=%0d addr=%0d data=%0d",
                   i, w_cyc[i], w_addr[i], w_data[i], e_cyc[i], e_addr[i], e_data[i]);
        end
      end
    end
    checks++; if (d_cyc.size() != 0) begin failures++; $display("FAIL single_all_done: got %0d pulses required 0", d_cyc.size()); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] d;
    int t, t9;
    int img[144];
    pulse_start();
    clear_logs();
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 16; i++) d[i*16 +: 16] = 16'(k + 1);
      send(d, t);
      model_tile(12, 12, t, d, m_tr, m_tc);
      t9 = t;
    end
    repeat (20) @(negedge clk);
    checks++;
    if (w_cyc.size() != e_cyc.size()) begin
      failures++; $display("FAIL b2b_count: got %0d writes required %0d", w_cyc.size(), e_cyc.size());
    end else begin
      for (int i = 0; i < e_cyc.size(); i++) begin
        checks++;
        if (w_cyc[i] != e_cyc[i] || w_addr[i] != e_addr[i] || w_data[i] != e_data[i]) begin
          failures++;
          $display("FAIL b2b_write[%0d]: got cyc=%0d addr=%0d data=%0d required cyc=%0d addr=%0d data=%0d",
                   i, w_cyc[i], w_addr[i], w_data[i], e_cyc[i], e_addr[i], e_data[i]);
        end
      end
    end
    for (int a = 0; a < 144; a++) img[a] = -1;
    for (int i = 0; i < w_addr.size(); i++) if (w_addr[i] < 144) img[w_addr[i]] = w_data[i];
    for (int a = 0; a < 144; a++) begin
      checks++;
      if (img[a] != ((a / 12) / 4) * 3 + ((a % 12) / 4) + 1) begin
        failures++;
        $display("FAIL b2b_image[%0d]: got %0d required %0d", a, img[a], ((a / 12) / 4) * 3 + ((a % 12) / 4) + 1);
      end
    end
    checks++;
    if (d_cyc.size() != 1 || d_cyc[0] != t9 + 17) begin
      failures++;
      $display("FAIL b2b_all_done: got %0d pulses first at %0d required 1 pulse at %0d",
               d_cyc.size(), (d_cyc.size() > 0) ? d_cyc[0] : -1, t9 + 17);
    end
    clear_logs();
    send(rand_tile(255), t);
    repeat (18) @(negedge clk);
    checks++;
    if (w_cyc.size() == 0 || w_addr[0] != 0 || w_cyc[0] != t + 1) begin
      failures++;
      $display("FAIL b2b_restart: got %0d writes first addr=%0d cyc=%0d required addr=0 cyc=%0d",
               w_cyc.size(), (w_addr.size() > 0) ? w_addr[0] : -1, (w_cyc.size() > 0) ? w_cyc[0] : -1, t + 1);
    end
  endtask

  task automatic test_saturation();
    logic [255:0] d;
    int t;
    pulse_start();
    clear_logs();
    for (int i = 0; i < 16; i++) d[i*16 +: 16] = 16'd255;
    d[(2*4+1)*16 +: 16] = 16'd300;
    send(d, t);
    model_tile(12, 12, t, d, m_tr, m_tc);
    repeat (20) @(negedge clk);
    checks++;
    if (w_cyc.size() != 16) begin
      failures++; $display("FAIL sat_count: got %0d writes required 16", w_cyc.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (w_data[i] != 255 || w_addr[i] != e_addr[i]) begin
          failures++; $display("FAIL sat_write[%0d]: got addr=%0d data=%0d required addr=%0d data=255", i, w_addr[i], w_data[i], e_addr[i]);
        end
      end
      checks++;
      if (w_cyc[9] != t + 10 || w_addr[9] != 25) begin
        failures++; $display("FAIL sat_pos21: got cyc=%0d addr=%0d required cyc=%0d addr=25", w_cyc[9], w_addr[9], t + 10);
      end
    end
  endtask

  task automatic test_overflow();
    logic [255:0] d;
    int t;
    pulse_start();
    clear_logs();
    d = rand_tile(400);
    send(d, t);
    model_tile(12, 12, t, d, m_tr, m_tc);
    repeat (4) @(negedge clk);
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_before: got %b required 0", bus.overflow); end
    bus.tile_valid = 1'b1; bus.tile_data = rand_tile(400);
    @(negedge clk);
    bus.tile_valid = 1'b0;
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b required 1 at t+6", bus.overflow); end
    repeat (16) @(negedge clk);
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b required 1", bus.overflow); end
    checks++;
    if (w_cyc.size() != e_cyc.size()) begin
      failures++; $display("FAIL ovf_count: got %0d writes required %0d", w_cyc.size(), e_cyc.size());
    end else begin
      for (int i = 0; i < e_cyc.size(); i++) begin
        checks++;
        if (w_cyc[i] != e_cyc[i] || w_addr[i] != e_addr[i] || w_data[i] != e_data[i]) begin
          failures++;
          $display("FAIL ovf_write[%0d]: got cyc=%0d addr=%0d data=%0d required cyc=%0d addr=%0d data=%0d",
                   i, w_cyc[i], w_addr[i], w_data[i], e_cyc[i], e_addr[i], e_data[i]);
        end
      end
    end
    pulse_start();
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b required 0", bus.overflow); end
  endtask

  task automatic test_start_abort();
    logic [255:0] d;
    int t;
    pulse_start();
    clear_logs();
    d = rand_tile(400);
    send(d, t);
    model_tile(12, 12, t, d, m_tr, m_tc);
    repeat (7) @(negedge clk);
    bus.start = 1'b1; bus.tile_valid = 1'b1; bus.tile_data = rand_tile(400);
    @(negedge clk);
    bus.start = 1'b0; bus.tile_valid = 1'b0;
    m_tr = 0; m_tc = 0;
    checks++; if (bus.tile_ready !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b required 1 at t+9", bus.tile_ready); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL abort_we: got %b required 0 at t+9", bus.mem_we); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL abort_overflow: got %b required 0", bus.overflow); end
    repeat (20) @(negedge clk);
    checks++;
    if (w_cyc.size() != 8) begin
      failures++; $display("FAIL abort_count: got %0d writes required 8", w_cyc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (w_cyc[i] != e_cyc[i] || w_addr[i] != e_addr[i] || w_data[i] != e_data[i]) begin
          failures++;
          $display("FAIL abort_write[%0d]: got cyc=%0d addr=%0d data=%0d required cyc=%0d addr=%0d data=%0d",
                   i, w_cyc[i], w_addr[i], w_data[i], e_cyc[i], e_addr[i], e_data[i]);
        end
      end
    end
    clear_logs();
    d = rand_tile(400);
    send(d, t);
    model_tile(12, 12, t, d, m_tr, m_tc);
    repeat (18) @(negedge clk);
    checks++;
    if (w_cyc.size() != e_cyc.size()) begin
      failures++; $display("FAIL abort_next_count: got %0d writes required %0d", w_cyc.size(), e_cyc.size());
    end else begin
      for (int i = 0; i < e_cyc.size(); i++) begin
        checks++;
        if (w_cyc[i] != e_cyc[i] || w_addr[i] != e_addr[i] || w_data[i] != e_data[i]) begin
          failures++;
          $display("FAIL abort_next_write[%0d]: got cyc=%0d addr=%0d data=%0d required cyc=%0d addr=%0d data=%0d",
                   i, w_cyc[i], w_addr[i], w_data[i], e_cyc[i], e_addr[i], e_data[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [255:0] d;
    int t;
    pulse_start();
    clear_logs();
    for (int k = 0; k < 11; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      d = rand_tile(600);
      send(d, t);
      model_tile(12, 12, t, d, m_tr, m_tc);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (w_cyc.size() != e_cyc.size()) begin
      failures++; $display("FAIL rand_count: got %0d writes required %0d", w_cyc.size(), e_cyc.size());
    end else begin
      for (int i = 0; i < e_cyc.size(); i++) begin
        checks++;
        if (w_cyc[i] != e_cyc[i] || w_addr[i] != e_addr[i] || w_data[i] != e_data[i]) begin
          failures++;
          $display("FAIL rand_write[%0d]: got cyc=%0d addr=%0d data=%0d required cyc=%0d addr=%0d data=%0d",
                   i, w_cyc[i], w_addr[i], w_data[i], e_cyc[i], e_addr[i], e_data[i]);
        end
      end
    end
    checks++;
    if (d_cyc.size() != ed_cyc.size() || (d_cyc.size() > 0 && d_cyc[0] != ed_cyc[0])) begin
      failures++;
      $display("FAIL rand_all_done: got %0d pulses first at %0d required %0d first at %0d", d_cyc.size(),
               (d_cyc.size() > 0) ? d_cyc[0] : -1, ed_cyc.size(), (ed_cyc.size() > 0) ? ed_cyc[0] : -1);
    end
  endtask

  task automatic test_edge_tiles();
    logic [255:0] d;
    int ts[4];
    int tr6 = 0, tc6 = 0;
    int cnt;
    int exp_a[8] = '{4, 5, 10, 11, 16, 17, 22, 23};
    int got_a[$];
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      d = rand_tile(400);
      send6(d, ts[k]);
      model_tile(6, 6, ts[k], d, tr6, tc6);
    end
    repeat (20) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ts[k+1] - ts[k] != 17) begin
        failures++; $display("FAIL edge_tile_cycles[%0d]: got %0d required 17", k, ts[k+1] - ts[k]);
      end
    end
    cnt = 0;
    for (int i = 0; i < w6_cyc.size(); i++)
      if (w6_cyc[i] > ts[1] && w6_cyc[i] <= ts[1] + 16) begin cnt++; got_a.push_back(w6_addr[i]); end
    checks++;
    if (cnt != 8) begin
      failures++; $display("FAIL edge_tile01_count: got %0d writes required 8", cnt);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_a[i] != exp_a[i]) begin failures++; $display("FAIL edge_tile01_addr[%0d]: got %0d required %0d", i, got_a[i], exp_a[i]); end
      end
    end
    cnt = 0;
    for (int i = 0; i < w6_cyc.size(); i++) if (w6_cyc[i] > ts[3] && w6_cyc[i] <= ts[3] + 16) cnt++;
    checks++; if (cnt != 4) begin failures++; $display("FAIL edge_tile11_count: got %0d writes required 4", cnt); end
    checks++;
    if (w6_cyc.size() != e_cyc.size()) begin
      failures++; $display("FAIL edge_count: got %0d writes required %0d", w6_cyc.size(), e_cyc.size());
    end else begin
      for (int i = 0; i < e_cyc.size(); i++) begin
        checks++;
        if (w6_cyc[i] != e_cyc[i] || w6_addr[i] != e_addr[i] || w6_data[i] != e_data[i]) begin
          failures++;
          $display("FAIL edge_write[%0d]: got cyc=%0d addr=%0d data=%0d required cyc=%0d addr=%0d data=%0d",
                   i, w6_cyc[i], w6_addr[i], w6_data[i], e_cyc[i], e_addr[i], e_data[i]);
        end
      end
    end
    checks++;
    if (d6_cyc.size() != 1 || d6_cyc[0] != ts[3] + 17) begin
      failures++;
      $display("FAIL edge_all_done: got %0d pulses first at %0d required 1 at %0d",
               d6_cyc.size(), (d6_cyc.size() > 0) ? d6_cyc[0] : -1, ts[3] + 17);
    end
  endtask

  task automatic test_async_reset();
    int t;
    pulse_start();
    send(rand_tile(255), t);
    bus.tile_valid = 1'b1; bus.tile_data = rand_tile(255);
    @(negedge clk);
    bus.tile_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_we !== 1'b1 || bus.overflow !== 1'b1) begin
      failures++; $display("FAIL areset_pre: got mem_we=%b overflow=%b required 1 1", bus.mem_we, bus.overflow);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.tile_ready !== 1'b1) begin failures++; $display("FAIL areset_tile_ready: got %b required 1", bus.tile_ready); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL areset_mem_we: got %b required 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 8'd0) begin failures++; $display("FAIL areset_mem_addr: got %0d required 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 8'd0) begin failures++; $display("FAIL areset_mem_wdata: got %0d required 0", bus.mem_wdata); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL areset_overflow: got %b required 0", bus.overflow); end
    checks++; if (bus.all_done !== 1'b0) begin failures++; $display("FAIL areset_all_done: got %b required 0", bus.all_done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.tile_valid = 1'b0; bus.tile_data = '0;
    bus6.start = 1'b0; bus6.tile_valid = 1'b0; bus6.tile_data = '0;
    m_tr = 0; m_tc = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_overflow();
    test_start_abort();
    test_random();
    test_edge_tiles();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
